// File: rtl/iq_demod_pkg.sv
// Shared widths, saturation limits and carrier-table generators for the I/Q demodulator.
// Tables are elaborated from constant functions so they track SAMPLE_W / LUT_AW.
package iq_demod_pkg;

  localparam int unsigned DefSampleW = 8;
  localparam int unsigned DefLutAw   = 8;
  localparam int unsigned DefAccW    = 24;
  localparam int unsigned DefProdW   = 2 * DefSampleW;

  localparam logic signed [DefAccW-1:0] DefAccMax = {1'b0, {(DefAccW-1){1'b1}}};
  localparam logic signed [DefAccW-1:0] DefAccMin = {1'b1, {(DefAccW-1){1'b0}}};

  localparam real Pi = 3.14159265358979323846;

  function automatic int carrier_amp(int unsigned sample_w);
    return (1 << (sample_w - 1)) - 1;
  endfunction

  // int'() of a real rounds to nearest, which is the table definition.
  function automatic int cos_entry(int unsigned sample_w, int unsigned lut_aw, int unsigned k);
    real ang;
    ang = 2.0 * Pi * real'(k) / real'(1 << lut_aw);
    return int'(real'(carrier_amp(sample_w)) * $cos(ang));
  endfunction

  function automatic int sin_entry(int unsigned sample_w, int unsigned lut_aw, int unsigned k);
    real ang;
    ang = 2.0 * Pi * real'(k) / real'(1 << lut_aw);
    return int'(real'(carrier_amp(sample_w)) * $sin(ang));
  endfunction

endpackage

// File: rtl/iq_carrier_rom.sv
// Cosine/sine carrier ROM with a registered read (one cycle from phase to cos_val/sin_val).
module iq_carrier_rom
  import iq_demod_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned LUT_AW   = DefLutAw
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [LUT_AW-1:0]          phase,
  output logic signed [SAMPLE_W-1:0] cos_val,
  output logic signed [SAMPLE_W-1:0] sin_val
);

  localparam int Depth = 1 << LUT_AW;

  logic signed [SAMPLE_W-1:0] cos_tbl [Depth];
  logic signed [SAMPLE_W-1:0] sin_tbl [Depth];

  for (genvar k = 0; k < Depth; k++) begin : g_tbl
    assign cos_tbl[k] = SAMPLE_W'(cos_entry(SAMPLE_W, LUT_AW, k));
    assign sin_tbl[k] = SAMPLE_W'(sin_entry(SAMPLE_W, LUT_AW, k));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cos_val <= '0;
      sin_val <= '0;
    end else begin
      cos_val <= cos_tbl[phase];
      sin_val <= sin_tbl[phase];
    end
  end

endmodule

// File: rtl/iq_demodulator.sv
// Coherent I/Q integrate-and-dump demodulator: 4-stage pipeline, saturating accumulators.
// Optional QPSK hard-decision output dec_bits when IQ_DEMOD_DECISION_EN is defined.
module iq_demodulator
  import iq_demod_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DefSampleW,
  parameter int unsigned LUT_AW     = DefLutAw,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned SYMBOL_LEN = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sym_sync,
  input  logic [LUT_AW-1:0]          phase_offset,
  output logic signed [ACC_W-1:0]    i_out,
  output logic signed [ACC_W-1:0]    q_out,
  output logic                       sym_valid,
  output logic                       overflow
`ifdef IQ_DEMOD_DECISION_EN
  ,
  output logic [1:0]                 dec_bits
`endif
);

  localparam int unsigned ProdW = 2 * SAMPLE_W;
  localparam int unsigned CntW  = $clog2(SYMBOL_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(SYMBOL_LEN - 1);
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic [LUT_AW-1:0] phase_q, phase_d, phase_cur;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_cur;

  logic                       s0_valid_q, s0_last_q, s0_sync_q;
  logic signed [SAMPLE_W-1:0] s0_sample_q;
  logic [LUT_AW-1:0]          s0_phase_q;
  logic                       s1_valid_q, s1_last_q, s1_sync_q;
  logic signed [SAMPLE_W-1:0] s1_sample_q;
  logic signed [SAMPLE_W-1:0] rom_cos, rom_sin;
  logic                       s2_valid_q, s2_last_q, s2_sync_q;
  logic signed [ProdW-1:0]    samp_ext, cos_ext, sin_ext;
  logic signed [ProdW-1:0]    prod_i_q, prod_q_q;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q, acc_i_base, acc_q_base, sat_i, sat_q;
  logic [ACC_W:0]          sum_i, sum_q;
  logic                    ovf_i, ovf_q;
  logic signed [ACC_W-1:0] i_out_q, q_out_q;
  logic                    sym_valid_q, overflow_q;

  // A qualified sym_sync overrides phase and count for the sample it arrives with.
  always_comb begin
    phase_cur = sym_sync ? phase_offset : phase_q;
    cnt_cur   = sym_sync ? '0 : cnt_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    if (sample_valid) begin
      phase_d = phase_cur + 1'b1;
      cnt_d   = (cnt_cur == CntLast) ? '0 : cnt_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      cnt_q       <= '0;
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_sync_q   <= 1'b0;
      s0_sample_q <= '0;
      s0_phase_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sync_q   <= 1'b0;
      s1_sample_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sync_q   <= 1'b0;
      prod_i_q    <= '0;
      prod_q_q    <= '0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      s0_valid_q  <= sample_valid;
      s0_last_q   <= sample_valid & (cnt_cur == CntLast);
      s0_sync_q   <= sample_valid & sym_sync;
      s0_sample_q <= sample_in;
      s0_phase_q  <= phase_cur;
      s1_valid_q  <= s0_valid_q;
      s1_last_q   <= s0_last_q;
      s1_sync_q   <= s0_sync_q;
      s1_sample_q <= s0_sample_q;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_sync_q   <= s1_sync_q;
      prod_i_q    <= samp_ext * cos_ext;
      prod_q_q    <= samp_ext * sin_ext;
    end
  end

  iq_carrier_rom #(
    .SAMPLE_W(SAMPLE_W),
    .LUT_AW  (LUT_AW)
  ) u_rom (
    .clk    (clk),
    .reset_n(reset_n),
    .phase  (s0_phase_q),
    .cos_val(rom_cos),
    .sin_val(rom_sin)
  );

  assign samp_ext = {{SAMPLE_W{s1_sample_q[SAMPLE_W-1]}}, s1_sample_q};
  assign cos_ext  = {{SAMPLE_W{rom_cos[SAMPLE_W-1]}}, rom_cos};
  assign sin_ext  = {{SAMPLE_W{rom_sin[SAMPLE_W-1]}}, rom_sin};

  // One guard bit; a mismatch between the top two sum bits means the result left range.
  always_comb begin
    acc_i_base = s2_sync_q ? '0 : acc_i_q;
    acc_q_base = s2_sync_q ? '0 : acc_q_q;
    sum_i = {acc_i_base[ACC_W-1], acc_i_base} + {{(ACC_W+1-ProdW){prod_i_q[ProdW-1]}}, prod_i_q};
    sum_q = {acc_q_base[ACC_W-1], acc_q_base} + {{(ACC_W+1-ProdW){prod_q_q[ProdW-1]}}, prod_q_q};
    ovf_i = sum_i[ACC_W] != sum_i[ACC_W-1];
    ovf_q = sum_q[ACC_W] != sum_q[ACC_W-1];
    sat_i = ovf_i ? (sum_i[ACC_W] ? AccMin : AccMax) : sum_i[ACC_W-1:0];
    sat_q = ovf_q ? (sum_q[ACC_W] ? AccMin : AccMax) : sum_q[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      sym_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      if (s2_valid_q) begin
        if (ovf_i || ovf_q) overflow_q <= 1'b1;
        if (s2_last_q) begin
          i_out_q     <= sat_i;
          q_out_q     <= sat_q;
          sym_valid_q <= 1'b1;
          acc_i_q     <= '0;
          acc_q_q     <= '0;
        end else begin
          acc_i_q <= sat_i;
          acc_q_q <= sat_q;
        end
      end
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign sym_valid = sym_valid_q;
  assign overflow  = overflow_q;

`ifdef IQ_DEMOD_DECISION_EN
  logic [1:0] dec_bits_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_bits_q <= 2'b00;
    end else if (s2_valid_q && s2_last_q) begin
      dec_bits_q <= {sat_i[ACC_W-1], sat_q[ACC_W-1]};
    end
  end

  assign dec_bits = dec_bits_q;
`endif

endmodule

// File: tb/tb_iq_demodulator.sv
// Directed bench for iq_demodulator: symbol-level reference model plus literal spot checks.
// Honours IQ_DEMOD_DECISION_EN when defined for the build.
`timescale 1ns/1ps
module tb_iq_demodulator;

  localparam int SymLen = 256;
  localparam longint AccMax = 8388607;
  localparam longint AccMin = -8388608;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sample_valid = 1'b0, sym_sync = 1'b0;
  logic signed [7:0] sample_in = '0;
  logic [7:0] phase_offset = '0;
  logic signed [23:0] i_out, q_out;
  logic sym_valid, overflow;

  logic sample_valid2 = 1'b0, sym_sync2 = 1'b0;
  logic signed [7:0] sample_in2 = '0;
  logic signed [17:0] i_out2, q_out2;
  logic sym_valid2, overflow2;

`ifdef IQ_DEMOD_DECISION_EN
  logic [1:0] dec_bits, dec_bits2;
`endif

  always #5 clk = ~clk;

  iq_demodulator #(.SAMPLE_W(8), .LUT_AW(8), .ACC_W(24), .SYMBOL_LEN(256)) u_dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .sym_sync(sym_sync), .phase_offset(phase_offset), .i_out(i_out), .q_out(q_out),
    .sym_valid(sym_valid), .overflow(overflow)
`ifdef IQ_DEMOD_DECISION_EN
    , .dec_bits(dec_bits)
`endif
  );

  iq_demodulator #(.SAMPLE_W(8), .LUT_AW(8), .ACC_W(18), .SYMBOL_LEN(1024)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid2), .sample_in(sample_in2),
    .sym_sync(sym_sync2), .phase_offset(8'd0), .i_out(i_out2), .q_out(q_out2),
    .sym_valid(sym_valid2), .overflow(overflow2)
`ifdef IQ_DEMOD_DECISION_EN
    , .dec_bits(dec_bits2)
`endif
  );

  typedef struct {
    int     cyc;
    longint i;
    longint q;
  } dump_t;

  int cos_tbl[256];
  int sin_tbl[256];
  int n_vec = 0, n_fail = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  dump_t exp_q[$];
  int m_phase, m_cnt, ovf_cyc, last_sv_cyc, sv_count, last_drive_cyc;
  longint m_acc_i, m_acc_q, hold_i, hold_q, g_cos_i;
  bit cmp_exp_sv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input longint act, input string req);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %s", name, act, req);
    end
  endtask

  task automatic sat_acc(inout longint acc, input longint p);
    acc = acc + p;
    if (acc > AccMax || acc < AccMin) begin
      acc = (acc > AccMax) ? AccMax : AccMin;
      if (ovf_cyc > cyc + 4) ovf_cyc = cyc + 4;
    end
  endtask

  // Reference: what one accepted sample does to the symbol integral, visible 3 edges later.
  task automatic model_accept(input int s, input bit sync, input int off);
    if (sync) begin
      m_phase = off; m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
    end
    sat_acc(m_acc_i, longint'(s * cos_tbl[m_phase]));
    sat_acc(m_acc_q, longint'(s * sin_tbl[m_phase]));
    if (m_cnt == SymLen - 1) begin
      exp_q.push_back('{cyc: cyc + 4, i: m_acc_i, q: m_acc_q});
      m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_phase = (m_phase + 1) % 256;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_phase = 0; m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
    hold_i = 0; hold_q = 0; ovf_cyc = 32'h7fff_ffff;
  endtask

  task automatic drive(input bit v, input int s, input bit sy, input int off);
    @(negedge clk);
    last_drive_cyc = cyc;
    sample_valid = v; sample_in = 8'(s); sym_sync = sy; phase_offset = 8'(off);
    if (v) model_accept(s, sy, off);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_valid = 1'b0; sym_sync = 1'b0; sample_valid2 = 1'b0; sym_sync2 = 1'b0;
    model_clear();
    #1;
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_i_out2", i_out2, 0);
    check("rst_overflow2", overflow2, 0);
`ifdef IQ_DEMOD_DECISION_EN
    check("rst_dec_bits", dec_bits, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;
  endtask

  // Compare process: every cycle out of reset, DUT outputs against the model's timeline.
  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++; n_fail++;
        $display("FAIL sym_valid_missed: no pulse at cycle %0d, expected one", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      cmp_exp_sv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("sym_valid", sym_valid, cmp_exp_sv);
      if (sym_valid) begin
        last_sv_cyc = cyc;
        sv_count++;
      end
      if (cmp_exp_sv) begin
        hold_i = exp_q[0].i;
        hold_q = exp_q[0].q;
        void'(exp_q.pop_front());
      end
      check("i_out", i_out, hold_i);
      check("q_out", q_out, hold_q);
      check("overflow", overflow, (cyc >= ovf_cyc) ? 1 : 0);
`ifdef IQ_DEMOD_DECISION_EN
      check("dec_bits", dec_bits, {hold_i < 0, hold_q < 0});
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, sv0;
    bit found;
    for (int k = 0; k < 256; k++) begin
      cos_tbl[k] = int'(127.0 * $cos(2.0 * 3.14159265358979 * real'(k) / 256.0));
      sin_tbl[k] = int'(127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0));
    end
    sv_count = 0; last_sv_cyc = 0;
    model_clear();
    // Pin the model's carrier tables to hand values.
    check("tbl_cos0", cos_tbl[0], 127);
    check("tbl_cos64", cos_tbl[64], 0);
    check("tbl_cos128", cos_tbl[128], -127);
    check("tbl_sin64", sin_tbl[64], 127);
    check("tbl_sin32", sin_tbl[32], 90);

    do_reset();

    // Zero samples: single dump 259 cycles after first accept, outputs zero.
    drive(1'b1, 0, 1'b0, 0);
    c0 = last_drive_cyc;
    for (int k = 1; k < 256; k++) drive(1'b1, 0, 1'b0, 0);
    idle(8);
    check("zero_latency", last_sv_cyc - c0, 259);
    check("zero_i", i_out, 0);
    check("zero_q", q_out, 0);
    check("zero_overflow", overflow, 0);

    // Matched cosine: sum of cos^2.
    sv0 = sv_count;
    for (int k = 0; k < 256; k++) drive(1'b1, cos_tbl[k], k == 0, 0);
    idle(8);
    g_cos_i = hold_i;
    check("cos_sv_count", sv_count - sv0, 1);
    check_cond("cos_i_range", i_out > 2055000 && i_out < 2075000, i_out, "~2.06e6");
    check_cond("cos_q_small", q_out <= 256 && q_out >= -256, q_out, "|q|<=256");
`ifdef IQ_DEMOD_DECISION_EN
    check("cos_dec", dec_bits, 0);
`endif

    // Constant +100: table sums cancel exactly.
    for (int k = 0; k < 256; k++) drive(1'b1, 100, k == 0, 0);
    idle(8);
    check("dc_i", i_out, 0);
    check("dc_q", q_out, 0);

    // Alternating sample_valid: same integral as contiguous.
    sv0 = sv_count;
    for (int n = 0; n < 512; n++) begin
      if (n % 2 == 0) drive(1'b1, cos_tbl[n / 2], n == 0, 0);
      else drive(1'b0, 0, 1'b0, 0);
    end
    idle(8);
    check("gap_sv_count", sv_count - sv0, 1);
    check("gap_i", i_out, g_cos_i);

    // Resync at cnt=100 with offset 64: truncated symbol dropped, sin against -sin carrier.
    sv0 = sv_count;
    for (int k = 0; k < 100; k++) drive(1'b1, 50, k == 0, 0);
    for (int k = 0; k < 256; k++) drive(1'b1, sin_tbl[k], k == 0, 64);
    idle(8);
    check("resync_sv_count", sv_count - sv0, 1);
    check_cond("resync_i_neg", i_out < -2000000, i_out, "< -2.0e6");
    check_cond("resync_q_small", q_out <= 256 && q_out >= -256, q_out, "|q|<=256");

    // Mid-symbol reset, then restart from phase 0 / cnt 0 without sym_sync.
    for (int k = 0; k < 50; k++) drive(1'b1, 77, 1'b0, 0);
    do_reset();
    for (int k = 0; k < 256; k++) drive(1'b1, cos_tbl[k], 1'b0, 0);
    idle(8);
    check("post_reset_i", i_out, g_cos_i);

    // Narrow accumulator, long symbol, sign-matched samples: positive saturation.
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      sample_valid2 = 1'b1;
      sym_sync2 = (k == 0);
      sample_in2 = (cos_tbl[k % 256] >= 0) ? 8'sd127 : -8'sd128;
    end
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      sample_valid2 = 1'b0; sym_sync2 = 1'b0;
      if (sym_valid2) begin
        found = 1'b1;
        check("sat_i_clamp", i_out2, 131071);
        check("sat_overflow", overflow2, 1);
      end
    end
    check("sat_sym_valid_seen", found, 1);
    idle(4);
    check("sat_overflow_sticky", overflow2, 1);

    do_reset();
    idle(4);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_demodulator.md
# iq_demodulator

Coherent I/Q demodulator for the receive path. Mixes a stream of signed received samples against an internally generated cosine/sine carrier and integrates over each symbol period (integrate-and-dump). Emits one signed I/Q accumulator pair per symbol with a one-cycle valid strobe. It sits downstream of the ADC/sample front end and upstream of symbol decision and framing logic, and is the receive counterpart of the team's LUT-based carrier generator.

## Interface
Parameters:
- SAMPLE_W, 8, width of received sample and carrier LUT entries (signed)
- LUT_AW, 8, carrier LUT address width; carrier period = 2^LUT_AW accepted samples
- ACC_W, 24, accumulator and output width (signed)
- SYMBOL_LEN, 256, accepted samples per symbol (≥2)

Ports (one clock `clk`; reset `reset_n` is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  sample_in accepted on this edge
- sample_in  in  SAMPLE_W  signed received sample
- sym_sync  in  1  qualified by sample_valid; marks the first sample of a new symbol
- phase_offset  in  LUT_AW  carrier phase loaded on sym_sync
- i_out  out  ACC_W  signed in-phase integral (Σ sample·cos)
- q_out  out  ACC_W  signed quadrature integral (Σ sample·sin)
- sym_valid  out  1  one-cycle pulse; i_out/q_out hold a new symbol
- overflow  out  1  sticky; an accumulator saturated

## Operation
- Phase counter `phase` (LUT_AW bits) advances by 1 per accepted sample and wraps 2^LUT_AW−1 → 0. It is held when sample_valid=0.
- Symbol counter `cnt` counts accepted samples 0..SYMBOL_LEN−1. The sample with cnt=SYMBOL_LEN−1 is the last sample of the symbol (dump); cnt then wraps to 0.
- sym_sync=1 with sample_valid=1 does the following:
  - the current sample uses phase=phase_offset;
  - cnt=0 for this sample;
  - the in-flight partial accumulation is discarded and no sym_valid is issued for it.
- sym_sync with sample_valid=0 is ignored.
- Carrier tables: cos[k]=round((2^(SAMPLE_W−1)−1)·cos(2πk/2^LUT_AW)); sin similarly.
- Products are full precision, 2·SAMPLE_W bits signed, and are sign-extended into ACC_W.
- Accumulation saturates to ±(2^(ACC_W−1)−1 / −2^(ACC_W−1)). Any saturation sets overflow; only reset clears it.
- Dump cycle: i_out/q_out ← acc + final product (saturated), sym_valid=1, and the accumulators restart from 0 with no dropped sample. If a sample marking the first of the next symbol is in the pipeline, it adds to the fresh accumulator.
- i_out/q_out hold their value between dumps.
- Reset values: i_out=0, q_out=0, sym_valid=0, overflow=0, phase=0, cnt=0, accumulators=0, pipeline valids=0.
- Reset mid-symbol discards all partial state. The first sample accepted after release uses phase 0 and cnt 0.

## Timing
- Pipeline stages, for a sample accepted at edge N:
  - N: sample and phase registered.
  - N+1: ROM outputs cos/sin (registered read).
  - N+2: products registered.
  - N+3: accumulate or dump.
- sym_valid is high in the cycle after edge N+3 of the dump sample: 3-cycle latency from acceptance.
- Back-to-back samples every cycle are supported, with no stalls and no backpressure.
- Gaps in sample_valid bubble through; valid bits travel with each stage.
- Minimum sym_valid spacing equals SYMBOL_LEN cycles.

## Configuration
- IQ_DEMOD_DECISION_EN defined: adds output port `dec_bits` [1:0], reset 0.
  - It is updated on the same edge as i_out/q_out: dec_bits = {i<0, q<0} (QPSK Gray hard decision).
- Not defined: port absent and no decision logic. All other behaviour is identical.

## Structure
- Package `iq_demod_pkg`:
  - default widths SAMPLE_W, LUT_AW, ACC_W;
  - product width constant;
  - saturation limit constants;
  - constant functions generating the sin/cos table contents.
- Sub-module `iq_carrier_rom`: phase in, registered cos/sin out, 1-cycle read latency.
- Phase/symbol counters, multipliers, accumulators and saturation stay in iq_demodulator.

## Test plan
- Reset, then sample_in=0 with sample_valid=1 for 256 cycles → one sym_valid at cycle 259 after the first accept; i_out=q_out=0; overflow=0.
- sym_sync with phase_offset=0, then sample_in=cos[k] for k=0..255 → i_out equals the golden Σcos[k]² (≈+2.06·10^6); |q_out|≤256; dec_bits=2'b00 when enabled.
- Constant sample_in=+100 for one symbol from phase 0 → i_out=q_out=0 exactly (table sums are zero).
- sample_valid toggling 1/0 for 512 cycles → sym_valid exactly once, with a result identical to the contiguous case.
- sym_sync asserted at cnt=100 with phase_offset=64 → no sym_valid for the truncated symbol. The next sym_valid comes after 256 further accepts; sample_in=sin[k] gives i_out ≈ the expected Σsin²·sign per the golden model.
- SYMBOL_LEN=1024, ACC_W=18, sample_in=−128 against matching phase → overflow=1 and i_out clamps at +131071. reset_n pulsed mid-symbol → all outputs 0 on the next cycle.
